// File: rtl/hsi_m_rx_ctrl.sv
// hsi_m_rx_ctrl: HSI master-side receive controller.
// Frames a slave reply (HDR, LEN, payload, CRC_H, CRC_L) from decoder byte strobes,
// checks CRC16-CCITT over HDR/LEN/payload, forwards payload bytes and reports status.
// Build option: define HSI_RX_ERR_CNT_EN to add the saturating rx_err_cnt output.
module hsi_m_rx_ctrl #(
   parameter int unsigned MAX_LEN       = 32,
   parameter int unsigned BYTE_TO_TICKS = 2000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rx_en,
   input  logic       dec_start_bit,
   input  logic [7:0] dec_q,
   input  logic       dec_q_rdy,
   input  logic       dec_err,
   output logic       rx_start_bit_accepted,
   output logic       rx_frame_end,
   output logic       rx_err,
   output logic       rx_service_req,
   output logic       rx_sd_busy,
   output logic [7:0] rx_d,
`ifdef HSI_RX_ERR_CNT_EN
   output logic [7:0] rx_err_cnt,
`endif
   output logic       rx_d_rdy
);

   localparam int unsigned TICK_W = $clog2(BYTE_TO_TICKS);

   typedef enum logic [2:0] {
      StIdle, StHdr, StLen, StData, StCrcH, StCrcL, StDone
   } state_e;

   state_e            state;
   logic [15:0]       crc;
   logic [7:0]        crc_hi;
   logic [7:0]        frame_len;
   logic [7:0]        byte_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              hdr_svc;
   logic              hdr_busy;

   logic              active;
   logic              timeout;
   logic              byte_ok;
   logic              len_bad;
   logic              end_frame;
   logic              end_err;
   logic [15:0]       crc_next;

   // CRC16-CCITT (poly 0x1021), one byte MSB-first, non-reflected.
   function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   assign crc_next = crc16_upd(crc, dec_q);
   assign active   = (state != StIdle) && (state != StDone);
   // The counter reaches BYTE_TO_TICKS-1 on the coming edge.
   assign timeout  = active && (tick_cnt == TICK_W'(BYTE_TO_TICKS - 2));
   assign byte_ok  = dec_q_rdy && !dec_err;
   assign len_bad  = {24'd0, dec_q} > MAX_LEN;

   // Decide whether this cycle closes the frame and whether it closes with an error.
   always_comb begin
      end_frame = 1'b0;
      end_err   = 1'b0;
      if (active) begin
         if (dec_err) begin
            end_frame = 1'b1;
            end_err   = 1'b1;
         end else if (dec_q_rdy) begin
            // A byte arriving on the timeout cycle is still accepted.
            if (state == StLen && len_bad) begin
               end_frame = 1'b1;
               end_err   = 1'b1;
            end else if (state == StCrcL) begin
               end_frame = 1'b1;
               end_err   = ({crc_hi, dec_q} != crc);
            end
         end else if (timeout) begin
            end_frame = 1'b1;
            end_err   = 1'b1;
         end
      end
   end

   // Frame FSM with registered status and data outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state                 <= StIdle;
         crc                   <= 16'hFFFF;
         crc_hi                <= 8'd0;
         frame_len             <= 8'd0;
         byte_cnt              <= 8'd0;
         tick_cnt              <= '0;
         hdr_svc               <= 1'b0;
         hdr_busy              <= 1'b0;
         rx_start_bit_accepted <= 1'b0;
         rx_frame_end          <= 1'b0;
         rx_err                <= 1'b0;
         rx_service_req        <= 1'b0;
         rx_sd_busy            <= 1'b0;
         rx_d                  <= 8'd0;
         rx_d_rdy              <= 1'b0;
      end else begin
         rx_start_bit_accepted <= 1'b0;
         rx_frame_end          <= 1'b0;
         rx_d_rdy              <= 1'b0;
         if (!rx_en) begin
            // Abandon silently: no frame end, status flags untouched.
            state <= StIdle;
         end else begin
            case (state)
               StIdle: begin
                  if (dec_start_bit) begin
                     rx_start_bit_accepted <= 1'b1;
                     rx_err                <= 1'b0;
                     crc                   <= 16'hFFFF;
                     tick_cnt              <= '0;
                     state                 <= StHdr;
                  end
               end
               StDone: begin
                  state <= StIdle;
               end
               default: begin
                  if (end_frame) begin
                     state        <= StDone;
                     rx_frame_end <= 1'b1;
                     rx_err       <= end_err;
                     if (!end_err) begin
                        rx_service_req <= hdr_svc;
                        rx_sd_busy     <= hdr_busy;
                     end
                  end else if (byte_ok) begin
                     tick_cnt <= '0;
                     case (state)
                        StHdr: begin
                           hdr_svc  <= dec_q[5];
                           hdr_busy <= dec_q[4];
                           crc      <= crc_next;
                           state    <= StLen;
                        end
                        StLen: begin
                           frame_len <= dec_q;
                           byte_cnt  <= 8'd0;
                           crc       <= crc_next;
                           state     <= (dec_q == 8'd0) ? StCrcH : StData;
                        end
                        StData: begin
                           rx_d     <= dec_q;
                           rx_d_rdy <= 1'b1;
                           crc      <= crc_next;
                           byte_cnt <= byte_cnt + 8'd1;
                           if (byte_cnt + 8'd1 == frame_len) state <= StCrcH;
                        end
                        StCrcH: begin
                           crc_hi <= dec_q;
                           state  <= StCrcL;
                        end
                        default: ;
                     endcase
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            endcase
         end
      end
   end

`ifdef HSI_RX_ERR_CNT_EN
   // Count errored frames during the DONE cycle; saturates, cleared only by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_err_cnt <= 8'd0;
      end else if (state == StDone && rx_err && rx_err_cnt != 8'hFF) begin
         rx_err_cnt <= rx_err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hsi_m_rx_ctrl.sv
// tb_hsi_m_rx_ctrl: directed bench for hsi_m_rx_ctrl (set HSI_RX_ERR_CNT_EN to cover the counter).
module tb_hsi_m_rx_ctrl;

   localparam int unsigned MAX_LEN       = 32;
   localparam int unsigned BYTE_TO_TICKS = 2000;

   logic       clk           = 1'b0;
   logic       n_rst         = 1'b0;
   logic       rx_en         = 1'b0;
   logic       dec_start_bit = 1'b0;
   logic [7:0] dec_q         = 8'd0;
   logic       dec_q_rdy     = 1'b0;
   logic       dec_err       = 1'b0;
   logic       rx_start_bit_accepted;
   logic       rx_frame_end;
   logic       rx_err;
   logic       rx_service_req;
   logic       rx_sd_busy;
   logic [7:0] rx_d;
   logic       rx_d_rdy;
`ifdef HSI_RX_ERR_CNT_EN
   logic [7:0] rx_err_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int n_end = 0;
   int n_acc = 0;
   int n_drdy = 0;
   int exp_err_cnt = 0;
   int snap;
   int lat;
   logic [15:0] c;

   hsi_m_rx_ctrl #(
      .MAX_LEN      (MAX_LEN),
      .BYTE_TO_TICKS(BYTE_TO_TICKS)
   ) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .rx_en                (rx_en),
      .dec_start_bit        (dec_start_bit),
      .dec_q                (dec_q),
      .dec_q_rdy            (dec_q_rdy),
      .dec_err              (dec_err),
      .rx_start_bit_accepted(rx_start_bit_accepted),
      .rx_frame_end         (rx_frame_end),
      .rx_err               (rx_err),
      .rx_service_req       (rx_service_req),
      .rx_sd_busy           (rx_sd_busy),
      .rx_d                 (rx_d),
`ifdef HSI_RX_ERR_CNT_EN
      .rx_err_cnt           (rx_err_cnt),
`endif
      .rx_d_rdy             (rx_d_rdy)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_frame_end)          n_end++;
      if (rx_start_bit_accepted) n_acc++;
      if (rx_d_rdy)              n_drdy++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference CRC: byte folded into the top, then eight conditional shifts.
   function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] r;
      r = c_in ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_bit();
      tick(); dec_start_bit = 1'b1;
      tick(); dec_start_bit = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      tick(); dec_q = b; dec_q_rdy = 1'b1;
      tick(); dec_q_rdy = 1'b0;
   endtask

   task automatic err_pulse();
      tick(); dec_err = 1'b1;
      tick(); dec_err = 1'b0;
   endtask

   initial begin
      rx_en = 1'b1;
      tick(); tick();
      check_eq("reset_outputs", {rx_start_bit_accepted, rx_frame_end, rx_err, rx_service_req,
                                 rx_sd_busy, rx_d, rx_d_rdy}, 32'd0);
`ifdef HSI_RX_ERR_CNT_EN
      check_eq("reset_err_cnt", rx_err_cnt, 32'd0);
`endif
      n_rst = 1'b1;
      tick();

      // Stray byte in IDLE and a start bit with rx_en low are both ignored.
      send(8'h55); tick(); tick();
      check_eq("idle_rdy_ignored", n_end, 32'd0);
      rx_en = 1'b0;
      start_bit(); tick();
      check_eq("start_rx_en_low", n_acc, 32'd0);
      rx_en = 1'b1;

      // Test 1: good frame, no payload.
      start_bit();
      check_eq("t1_accept", rx_start_bit_accepted, 32'd1);
      send(8'h20); send(8'h00); send(8'h1B);
      check_eq("t1_no_early_end", n_end, 32'd0);
      send(8'hE9);
      check_eq("t1_end", rx_frame_end, 32'd1);
      check_eq("t1_err", rx_err, 32'd0);
      check_eq("t1_flags", {rx_service_req, rx_sd_busy}, 32'b10);
      tick();
      check_eq("t1_one_end", n_end, 32'd1);
      check_eq("t1_no_drdy", n_drdy, 32'd0);

      // Test 2: bad CRC_L, flags hold.
      start_bit();
      send(8'h20); send(8'h00); send(8'h1B); send(8'hE8);
      check_eq("t2_end_err", {rx_frame_end, rx_err}, 32'b11);
      check_eq("t2_flags_hold", {rx_service_req, rx_sd_busy}, 32'b10);
      exp_err_cnt++;

      // Test 3: three payload bytes with model CRC.
      c = 16'hFFFF;
      c = crc_model(c, 8'h10); c = crc_model(c, 8'h03);
      c = crc_model(c, 8'hA5); c = crc_model(c, 8'h5A); c = crc_model(c, 8'hFF);
      start_bit();
      check_eq("t3_err_cleared", rx_err, 32'd0);
      snap = n_drdy;
      send(8'h10); send(8'h03);
      send(8'hA5); check_eq("t3_d0", {rx_d_rdy, rx_d}, {23'd0, 1'b1, 8'hA5});
      send(8'h5A); check_eq("t3_d1", {rx_d_rdy, rx_d}, {23'd0, 1'b1, 8'h5A});
      send(8'hFF); check_eq("t3_d2", {rx_d_rdy, rx_d}, {23'd0, 1'b1, 8'hFF});
      send(c[15:8]); send(c[7:0]);
      check_eq("t3_end_ok", {rx_frame_end, rx_err}, 32'b10);
      check_eq("t3_flags", {rx_service_req, rx_sd_busy}, 32'b01);
      check_eq("t3_drdy_count", n_drdy - snap, 32'd3);

      // Test 4: length above MAX_LEN ends the frame right after LEN.
      start_bit();
      send(8'h00); send(8'h21);
      check_eq("t4_len_err", {rx_frame_end, rx_err}, 32'b11);
      exp_err_cnt++;

      // Test 5a: silence after HDR.
      start_bit();
      send(8'h00);
      lat = 1;
      while (!rx_frame_end && lat < int'(BYTE_TO_TICKS) + 20) begin
         tick();
         lat++;
      end
      check_eq("t5_timeout_lat", lat, BYTE_TO_TICKS);
      check_eq("t5_timeout_err", rx_err, 32'd1);
      exp_err_cnt++;

      // Test 5b: dec_err mid-DATA.
      start_bit();
      send(8'h00); send(8'h02); send(8'hAA);
      err_pulse();
      check_eq("t5_dec_err", {rx_frame_end, rx_err}, 32'b11);
      exp_err_cnt++;

      // dec_err together with a strobe: the error wins.
      start_bit();
      send(8'h00); send(8'h00);
      tick(); dec_q = 8'h12; dec_q_rdy = 1'b1; dec_err = 1'b1;
      tick(); dec_q_rdy = 1'b0; dec_err = 1'b0;
      check_eq("err_with_rdy", {rx_frame_end, rx_err}, 32'b11);
      exp_err_cnt++;

      // Start bit inside a frame is ignored; zero-length good frame clears the flags.
      c = crc_model(crc_model(16'hFFFF, 8'h00), 8'h00);
      start_bit();
      send(8'h00);
      start_bit();
      check_eq("start_mid_frame", rx_start_bit_accepted, 32'd0);
      send(8'h00); send(c[15:8]); send(c[7:0]);
      check_eq("len0_end_ok", {rx_frame_end, rx_err}, 32'b10);
      check_eq("len0_flags", {rx_service_req, rx_sd_busy}, 32'b00);

      // Test 6: rx_en drops mid-DATA.
      start_bit();
      send(8'h10); send(8'h03); send(8'h11);
      snap = n_end;
      rx_en = 1'b0;
      tick();
      rx_en = 1'b1;
      send(8'h22); send(8'h33); tick(); tick();
      check_eq("t6_no_end", n_end - snap, 32'd0);
      check_eq("t6_flags_hold", {rx_err, rx_service_req, rx_sd_busy}, 32'b000);
      start_bit();
      check_eq("t6_restart", rx_start_bit_accepted, 32'd1);
      c = crc_model(crc_model(16'hFFFF, 8'h30), 8'h00);
      send(8'h30); send(8'h00); send(c[15:8]); send(c[7:0]);
      check_eq("t6_good_after", {rx_frame_end, rx_err, rx_service_req, rx_sd_busy}, 32'b1011);
      tick();
`ifdef HSI_RX_ERR_CNT_EN
      check_eq("err_cnt", rx_err_cnt, exp_err_cnt);
`endif

      // Async reset mid-frame.
      start_bit();
      send(8'h30); send(8'h01);
      #2 n_rst = 1'b0;
      #1;
      check_eq("async_reset", {rx_start_bit_accepted, rx_frame_end, rx_err, rx_service_req,
                               rx_sd_busy, rx_d, rx_d_rdy}, 32'd0);
`ifdef HSI_RX_ERR_CNT_EN
      check_eq("async_reset_cnt", rx_err_cnt, 32'd0);
`endif
      tick();
      n_rst = 1'b1;
      start_bit();
      check_eq("post_reset_accept", rx_start_bit_accepted, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
